axis_uart_rx: RTL and testbench

AXIS_UART_RX -- requirements
Module: axis_uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/axis_uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_axis_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the oversample ratio.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional parity support is selected by the macro UART_RX_PARITY_EN.
package uart_pkg;

    // Clock cycles per bit for each unit of prescale; the TX side will reuse it.
    localparam int OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK    // after a frame error, waiting for the line to return high
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from input to sync_o.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), async_i (raw input), sync_o (synchronized).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream master output holding one character.
// Latency: tvalid rises one cycle after the stop-bit sample of a good frame.
// Backpressure: single output register; a character arriving while it is still
//   full and not being accepted is dropped and rx_overrun_error pulses.
// Ports: clk, rst (sync, active-high); rxd (async serial in, idle high);
//   prescale (bit period = prescale*8 cycles, 0 acts as 1); m_axis_tdata/tvalid/
//   tready (output stream); rx_busy; rx_overrun_error / rx_frame_error pulses.
// Macro UART_RX_PARITY_EN adds an even-parity bit and the rx_parity_error pulse.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                  rx_parity_error,
`endif
    input  logic [15:0]           prescale
);

    localparam int CNT_W = 19;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [15:0]             pre_q, pre_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    ovr_q, ovr_d;
    logic                    ferr_q, ferr_d;
    logic                    good;
    logic                    par_ok;
    logic                    rxd_s;
    logic [15:0]             pre_eff;
    logic [CNT_W-1:0]        bit_cyc;
    logic [CNT_W-1:0]        half_cyc;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic pbad_q, pbad_d;
    assign par_ok          = !pbad_q;
    assign rx_parity_error = perr_q;
`else
    assign par_ok = 1'b1;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rxd),
        .sync_o  (rxd_s)
    );

    assign pre_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    // Counters load "period - 1" and the sample is taken in the cycle they read 0.
    // Half period comes from the live input: pre_q is only latched on this edge.
    assign bit_cyc  = CNT_W'(pre_q) * CNT_W'(OVERSAMPLE) - CNT_W'(1);
    assign half_cyc = CNT_W'(pre_eff) * CNT_W'(OVERSAMPLE / 2) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            pre_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
            pbad_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            pre_q    <= pre_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_d;
            pbad_q   <= pbad_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        pre_d    = pre_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        ovr_d    = 1'b0;
        ferr_d   = 1'b0;
        good     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d   = 1'b0;
        pbad_d   = pbad_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    pre_d   = pre_eff;
                    cnt_d   = half_cyc;
`ifdef UART_RX_PARITY_EN
                    pbad_d  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;   // glitch, not a real start bit
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = bit_cyc;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = rxd_s;
                    cnt_d                   = bit_cyc;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if (rxd_s != ^shift_q) begin
                        perr_d = 1'b1;
                        pbad_d = 1'b1;
                    end
                    state_d = ST_STOP;
                    cnt_d   = bit_cyc;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                        good    = par_ok;
                    end else begin
                        state_d = ST_BREAK;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rxd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (good) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign rx_busy          = (state_q != ST_IDLE) && (state_q != ST_BREAK);
    assign rx_overrun_error = ovr_q;
    assign rx_frame_error   = ferr_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed bench for axis_uart_rx: scoreboard queue of expected characters,
// checked by a free-running monitor on every output handshake.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_axis_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        rx_busy;
    logic        rx_overrun_error;
    logic        rx_frame_error;
    logic [15:0] prescale;
`ifdef UART_RX_PARITY_EN
    logic        rx_parity_error;
    int          perr_cnt = 0;
`endif

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0, tv_cycles = 0, ovr_cnt = 0, ferr_cnt = 0;
    int hs0, tv0, ovr0, ferr0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    axis_uart_rx #(.DATA_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
`ifdef UART_RX_PARITY_EN
        .rx_parity_error  (rx_parity_error),
`endif
        .prescale         (prescale)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted character, counts pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid) tv_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_char: got %0h expected none", m_axis_tdata);
                end else begin
                    check("tdata", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
                end
            end
            if (rx_overrun_error) ovr_cnt++;
            if (rx_frame_error)   ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (rx_parity_error)  perr_cnt++;
`endif
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b, input int bp);
        rxd = 1'b0;
        wait_clk(bp);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(bp);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_b;
        wait_clk(bp);
`endif
        rxd = stop_b;
        wait_clk(bp);
    endtask

    task automatic send_good(input logic [7:0] d, input int bp);
        send_frame(d, ^d, 1'b1, bp);
        rxd = 1'b1;
        wait_clk(2 * bp);
    endtask

    task automatic snap();
        hs0 = hs_cnt; tv0 = tv_cycles; ovr0 = ovr_cnt; ferr0 = ferr_cnt;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rxd = 1'b1; m_axis_tready = 1'b1; prescale = 16'd1;
        wait_clk(4);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        check("rst_ovr", {31'd0, rx_overrun_error}, 0);
        check("rst_ferr", {31'd0, rx_frame_error}, 0);
        rst = 1'b0;
        wait_clk(10);

        // 0xA5 at prescale 1, tready high: exactly one valid cycle, no errors.
        snap();
        exp_q.push_back(8'hA5);
        send_good(8'hA5, 8);
        check("a5_hs", hs_cnt - hs0, 1);
        check("a5_tv_cycles", tv_cycles - tv0, 1);
        check("a5_errs", (ovr_cnt - ovr0) + (ferr_cnt - ferr0), 0);

        // prescale 0 behaves like prescale 1.
        prescale = 16'd0;
        exp_q.push_back(8'h3A);
        send_good(8'h3A, 8);

        // prescale 2: 16-cycle bits.
        prescale = 16'd2;
        exp_q.push_back(8'h69);
        send_good(8'h69, 16);

        // prescale changed mid-frame is ignored for the frame in flight.
        prescale = 16'd1;
        exp_q.push_back(8'hB2);
        fork
            send_good(8'hB2, 8);
            begin
                wait_clk(12);
                prescale = 16'd3;
            end
        join
        prescale = 16'd1;

        // Overrun: hold tready low over two frames.
        snap();
        m_axis_tready = 1'b0;
        exp_q.push_back(8'h3C);
        send_good(8'h3C, 8);
        send_good(8'hC3, 8);
        check("ovr_tvalid", {31'd0, m_axis_tvalid}, 1);
        check("ovr_tdata", {24'd0, m_axis_tdata}, 8'h3C);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        m_axis_tready = 1'b1;
        wait_clk(5);
        check("ovr_hs", hs_cnt - hs0, 1);
        check("ovr_tvalid_clear", {31'd0, m_axis_tvalid}, 0);

        // Frame error with stop low, then a long break.
        snap();
        send_frame(8'h55, ^8'h55, 1'b0, 8);
        wait_clk(40);
        check("ferr_pulses", ferr_cnt - ferr0, 1);
        check("break_busy", {31'd0, rx_busy}, 0);
        check("ferr_no_tvalid", hs_cnt - hs0, 0);
        rxd = 1'b1;
        wait_clk(30);
        check("break_no_frame", hs_cnt - hs0, 0);
        check("break_idle_busy", {31'd0, rx_busy}, 0);

        // 3-cycle glitch with prescale 2.
        snap();
        prescale = 16'd2;
        rxd = 1'b0;
        wait_clk(3);
        check("glitch_busy_start", {31'd0, rx_busy}, 1);
        rxd = 1'b1;
        wait_clk(40);
        check("glitch_busy_end", {31'd0, rx_busy}, 0);
        check("glitch_no_out", hs_cnt - hs0, 0);
        check("glitch_no_err", (ovr_cnt - ovr0) + (ferr_cnt - ferr0), 0);
        prescale = 16'd1;

        // Reset during bit 4 of 0xFF, then receive 0x81.
        snap();
        rxd = 1'b0;
        wait_clk(8);
        rxd = 1'b1;
        wait_clk(36);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_tvalid", {31'd0, m_axis_tvalid}, 0);
        check("midrst_tdata", {24'd0, m_axis_tdata}, 0);
        check("midrst_busy", {31'd0, rx_busy}, 0);
        check("midrst_errs", {30'd0, rx_overrun_error, rx_frame_error}, 0);
        rst = 1'b0;
        wait_clk(20);
        exp_q.push_back(8'h81);
        send_good(8'h81, 8);
        check("post_rst_hs", hs_cnt - hs0, 1);
        check("post_rst_errs", (ovr_cnt - ovr0) + (ferr_cnt - ferr0), 0);

`ifdef UART_RX_PARITY_EN
        snap();
        begin
            int p0;
            p0 = perr_cnt;
            send_frame(8'h07, 1'b0, 1'b1, 8);
            rxd = 1'b1;
            wait_clk(16);
            check("par_bad_pulse", perr_cnt - p0, 1);
            check("par_bad_no_out", hs_cnt - hs0, 0);
            exp_q.push_back(8'h07);
            send_frame(8'h07, 1'b1, 1'b1, 8);
            rxd = 1'b1;
            wait_clk(16);
            check("par_good_no_pulse", perr_cnt - p0, 1);
            check("par_good_hs", hs_cnt - hs0, 1);
        end
`endif

        wait_clk(10);
        check("scoreboard_empty", exp_q.size(), 0);
        check("total_overruns", ovr_cnt, 1);
        check("total_frame_errs", ferr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
